palette_mux: RTL

Parametrised, pipelined colour-palette multiplexer for the Mandelbrot renderer. It maps a per-pixel iteration index to a DATA_WIDTH colour word through a writable DEPTH-entry palette. An optional rotation offset animates the palette (colour cycling), and a blanking path forces black outside the active video region. It sits between the iteration-count pipeline and the VGA output stage.

---
 rtl/palette_mux_if.sv | 30 +++
 rtl/palette_mux.sv | 88 ++++++++
 2 files changed

// File: rtl/palette_mux_if.sv
// Bus bundle for palette_mux: palette write port, rotation control, pixel in/out.
interface palette_mux_if #(
  parameter int DATA_WIDTH   = 12,
  parameter int SELECT_WIDTH = 4
);
  logic                    wr_en;
  logic [SELECT_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rot_en;
  logic                    rot_tick;
  logic                    rot_dir;
  logic                    in_valid;
  logic [SELECT_WIDTH-1:0] in_select;
  logic                    in_blank;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   o_q;
  logic [SELECT_WIDTH-1:0] offset;

  modport master (
    output wr_en, wr_addr, wr_data, rot_en, rot_tick, rot_dir,
           in_valid, in_select, in_blank,
    input  out_valid, o_q, offset
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rot_en, rot_tick, rot_dir,
           in_valid, in_select, in_blank,
    output out_valid, o_q, offset
  );
endinterface

// File: rtl/palette_mux.sv
// Rotating colour-palette lookup with blanking; 2-cycle latency, 1 pixel/cycle.
// No backpressure: a pixel is accepted every cycle in_valid is high.
module palette_mux #(
  parameter int DATA_WIDTH   = 12,
  parameter int SELECT_WIDTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  palette_mux_if.slave  bus
);
  localparam int DEPTH = 1 << SELECT_WIDTH;
  localparam int STEP  = ((1 << DATA_WIDTH) - 1) / (DEPTH - 1);

  typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] pal_t;

  function automatic pal_t grey_ramp();
    pal_t r;
    for (int i = 0; i < DEPTH; i++) begin
      r[i] = DATA_WIDTH'(i * STEP);
    end
    return r;
  endfunction

  localparam pal_t RAMP = grey_ramp();

  pal_t                    pal;
  pal_t                    pal_next;
  logic [SELECT_WIDTH-1:0] offset_q;
  logic [SELECT_WIDTH-1:0] idx1;
  logic                    blank1;
  logic                    v1;
  logic                    out_valid_q;
  logic [DATA_WIDTH-1:0]   q;

  always_comb begin
    pal_next = pal;
    if (bus.wr_en) begin
      pal_next[bus.wr_addr] = bus.wr_data;
    end
  end

  // Stage 2 reads pal (pre-edge contents), so a same-edge write is seen only by later pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pal <= RAMP;
    end else begin
      pal <= pal_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset_q <= '0;
    end else if (bus.rot_en && bus.rot_tick) begin
      offset_q <= bus.rot_dir ? offset_q - 1'b1 : offset_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      idx1   <= '0;
      blank1 <= 1'b0;
    end else begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        idx1   <= bus.in_select + offset_q;
        blank1 <= bus.in_blank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      q           <= '0;
    end else begin
      out_valid_q <= v1;
      if (v1) begin
        q <= blank1 ? '0 : pal[idx1];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.o_q       = q;
  assign bus.offset    = offset_q;
endmodule
